// File: rtl/ccd_cds_sampler.sv
// Correlated-double-sampling sequencer: watches CCD phases and issues reset/signal
// ADC sample strobes with pixel/line tracking and sticky sequencing error flags.
module ccd_cds_sampler #(
    parameter int N_PIX   = 1024,
    parameter int N_LINES = 1024,
    parameter int DELAY_R = 4,
    parameter int DELAY_S = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_enable,
    input  logic        i_phi_r,
    input  logic        i_phi_l2,
    input  logic        i_phi_p,
    input  logic        i_err_clr,
    output logic        o_shr,
    output logic        o_shs,
    output logic [11:0] o_pix_idx,
    output logic [11:0] o_line_idx,
    output logic        o_eol,
    output logic        o_eof,
    output logic [1:0]  o_err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT_R = 3'd1,
        S_DLY_R  = 3'd2,
        S_WAIT_S = 3'd3,
        S_DLY_S  = 3'd4
    } state_t;

    localparam logic [7:0]  DLY_R_L   = 8'(DELAY_R);
    localparam logic [7:0]  DLY_S_L   = 8'(DELAY_S);
    localparam logic [11:0] PIX_LAST  = 12'(N_PIX - 1);
    localparam logic [11:0] LINE_LAST = 12'(N_LINES - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_dly;
    logic [7:0]  w_dly_nxt;
    logic        r_phi_r_q1, r_phi_r_q2;
    logic        r_phi_l2_q1, r_phi_l2_q2;
    logic        r_phi_p_q1, r_phi_p_q2;
    logic        r_p_rise;
    logic [11:0] r_pix_cnt;
    logic        r_line_full;
    logic        w_r_fall, w_l2_fall, w_p_rise;
    logic        w_shr, w_shs, w_seq_err;
    logic        w_hold_clr, w_line_adv, w_ovr;
    logic        w_pix_last, w_line_last;

    assign w_r_fall    = r_phi_r_q2 & ~r_phi_r_q1;
    assign w_l2_fall   = r_phi_l2_q2 & ~r_phi_l2_q1;
    assign w_p_rise    = ~r_phi_p_q2 & r_phi_p_q1;
    assign w_pix_last  = (r_pix_cnt == PIX_LAST);
    assign w_line_last = (o_line_idx == LINE_LAST);
    assign w_hold_clr  = ~i_enable | (r_state == S_IDLE);
    // Line advance uses the registered rise so it lines up with the strobe pipeline depth.
    assign w_line_adv  = r_p_rise & (r_state != S_IDLE);
    assign w_ovr       = w_shs & r_line_full;

    // Next-state and strobe decode for the sampling sequence.
    always_comb begin
        w_state_nxt = r_state;
        w_dly_nxt   = r_dly;
        w_shr       = 1'b0;
        w_shs       = 1'b0;
        w_seq_err   = 1'b0;
        if (!i_enable) begin
            w_state_nxt = S_IDLE;
            w_dly_nxt   = 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_WAIT_R;
                end
                S_WAIT_R: begin
                    if (w_r_fall) begin
                        w_dly_nxt   = DLY_R_L;
                        w_state_nxt = S_DLY_R;
                    end else begin
                        w_state_nxt = S_WAIT_R;
                    end
                end
                S_DLY_R: begin
                    if (r_dly == 8'd0) begin
                        w_shr       = 1'b1;
                        w_state_nxt = S_WAIT_S;
                    end else begin
                        w_dly_nxt = r_dly - 8'd1;
                    end
                end
                S_WAIT_S, S_DLY_S: begin
                    // A reset-gate fall before the signal strobe means we lost a pixel: resync.
                    if (w_r_fall) begin
                        w_seq_err   = 1'b1;
                        w_dly_nxt   = DLY_R_L;
                        w_state_nxt = S_DLY_R;
                    end else if (r_state == S_WAIT_S) begin
                        if (w_l2_fall) begin
                            w_dly_nxt   = DLY_S_L;
                            w_state_nxt = S_DLY_S;
                        end else begin
                            w_state_nxt = S_WAIT_S;
                        end
                    end else if (r_dly == 8'd0) begin
                        w_shs       = 1'b1;
                        w_state_nxt = S_WAIT_R;
                    end else begin
                        w_dly_nxt = r_dly - 8'd1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_dly_nxt   = 8'd0;
                end
            endcase
        end
    end

    // State, edge detection, counters and all registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_dly       <= 8'd0;
            r_phi_r_q1  <= 1'b0;
            r_phi_r_q2  <= 1'b0;
            r_phi_l2_q1 <= 1'b0;
            r_phi_l2_q2 <= 1'b0;
            r_phi_p_q1  <= 1'b0;
            r_phi_p_q2  <= 1'b0;
            r_p_rise    <= 1'b0;
            r_pix_cnt   <= 12'd0;
            r_line_full <= 1'b0;
            o_shr       <= 1'b0;
            o_shs       <= 1'b0;
            o_pix_idx   <= 12'd0;
            o_line_idx  <= 12'd0;
            o_eol       <= 1'b0;
            o_eof       <= 1'b0;
            o_err       <= 2'b00;
        end else begin
            r_phi_r_q1  <= i_phi_r;
            r_phi_r_q2  <= r_phi_r_q1;
            r_phi_l2_q1 <= i_phi_l2;
            r_phi_l2_q2 <= r_phi_l2_q1;
            r_phi_p_q1  <= i_phi_p;
            r_phi_p_q2  <= r_phi_p_q1;
            r_p_rise    <= w_p_rise;
            r_state     <= w_state_nxt;
            r_dly       <= w_dly_nxt;
            o_shr       <= w_shr;
            o_shs       <= w_shs;
            o_eol       <= w_shs & w_pix_last;
            // Set wins over clear when both land in the same cycle.
            o_err       <= (o_err & ~{2{i_err_clr}}) | {w_ovr, w_seq_err};
            if (w_hold_clr) begin
                r_pix_cnt   <= 12'd0;
                r_line_full <= 1'b0;
                o_pix_idx   <= 12'd0;
                o_line_idx  <= 12'd0;
                o_eof       <= 1'b0;
            end else begin
                o_eof <= w_line_adv & w_line_last;
                if (w_shs) begin
                    o_pix_idx <= r_pix_cnt;
                end
                if (w_line_adv) begin
                    r_pix_cnt   <= 12'd0;
                    r_line_full <= 1'b0;
                    o_line_idx  <= w_line_last ? 12'd0 : o_line_idx + 12'd1;
                end else if (w_shs) begin
                    r_pix_cnt <= w_pix_last ? 12'd0 : r_pix_cnt + 12'd1;
                    if (w_pix_last) begin
                        r_line_full <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ccd_cds_sampler.sv
// Directed bench for ccd_cds_sampler: N_PIX=4, N_LINES=2, DELAY_R=DELAY_S=4.
module tb_ccd_cds_sampler;

    logic        i_clk = 1'b0;
    logic        i_rst, i_enable, i_phi_r, i_phi_l2, i_phi_p, i_err_clr;
    logic        o_shr, o_shs, o_eol, o_eof;
    logic [11:0] o_pix_idx, o_line_idx;
    logic [1:0]  o_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int shr_cnt = 0, shs_cnt = 0, eof_cnt = 0;
    int last_shr_cyc = -1, last_shs_cyc = -1, last_eof_cyc = -1;
    int last_pix = -1, last_eol = -1;

    ccd_cds_sampler #(.N_PIX(4), .N_LINES(2), .DELAY_R(4), .DELAY_S(4)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_enable(i_enable),
        .i_phi_r(i_phi_r), .i_phi_l2(i_phi_l2), .i_phi_p(i_phi_p),
        .i_err_clr(i_err_clr), .o_shr(o_shr), .o_shs(o_shs),
        .o_pix_idx(o_pix_idx), .o_line_idx(o_line_idx),
        .o_eol(o_eol), .o_eof(o_eof), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    // Record strobe events mid-cycle.
    always @(negedge i_clk) begin
        if (o_shr) begin shr_cnt++; last_shr_cyc = cyc; end
        if (o_shs) begin shs_cnt++; last_shs_cyc = cyc; last_pix = int'(o_pix_idx); last_eol = int'(o_eol); end
        if (o_eof) begin eof_cnt++; last_eof_cyc = cyc; end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_r(output int c);
        i_phi_r = 1'b1; tick(); tick();
        i_phi_r = 1'b0; c = cyc;
    endtask

    task automatic pulse_l2(output int c);
        i_phi_l2 = 1'b1; tick(); tick();
        i_phi_l2 = 1'b0; c = cyc;
    endtask

    task automatic pulse_p(output int c);
        i_phi_p = 1'b1; c = cyc; tick(); tick();
        i_phi_p = 1'b0;
    endtask

    task automatic do_pixel(input int exp_pix, input int exp_eol);
        int c_r, c_l;
        pulse_r(c_r);
        repeat (18) tick();
        chk("shr_time", last_shr_cyc, c_r + 7);
        pulse_l2(c_l);
        repeat (10) tick();
        chk("shs_time", last_shs_cyc, c_l + 7);
        chk("shs_pix", last_pix, exp_pix);
        chk("shs_eol", last_eol, exp_eol);
    endtask

    initial begin
        int c1, c2, cp, cl, s0, r0, e0;
        i_rst = 1'b1; i_enable = 1'b0; i_err_clr = 1'b0;
        i_phi_r = 1'b0; i_phi_l2 = 1'b0; i_phi_p = 1'b0;
        for (int i = 0; i < 5; i++) begin
            i_phi_r = ~i_phi_r; i_phi_l2 = ~i_phi_l2; i_phi_p = ~i_phi_p;
            tick();
        end
        chk("rst_shr", o_shr, 0);
        chk("rst_shs", o_shs, 0);
        chk("rst_pix", o_pix_idx, 0);
        chk("rst_line", o_line_idx, 0);
        chk("rst_eol_eof", {o_eol, o_eof}, 0);
        chk("rst_err", o_err, 0);
        i_rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            i_phi_r = ~i_phi_r; i_phi_l2 = ~i_phi_l2; i_phi_p = ~i_phi_p;
            tick();
        end
        i_phi_r = 1'b0; i_phi_l2 = 1'b0; i_phi_p = 1'b0;
        repeat (4) tick();
        chk("idle_strobes", shr_cnt + shs_cnt + eof_cnt, 0);
        chk("idle_err", o_err, 0);

        // Line 0: nominal pixels, eol on the last one.
        i_enable = 1'b1;
        repeat (3) tick();
        do_pixel(0, 0);
        chk("line0_idx", o_line_idx, 0);
        do_pixel(1, 0);
        do_pixel(2, 0);
        do_pixel(3, 1);
        chk("nominal_err", o_err, 0);
        pulse_p(cp);
        repeat (4) tick();
        chk("line_to_1", o_line_idx, 1);
        chk("no_eof_yet", eof_cnt, 0);

        // Line 1 then frame wrap.
        do_pixel(0, 0);
        do_pixel(1, 0);
        do_pixel(2, 0);
        do_pixel(3, 1);
        pulse_p(cp);
        repeat (4) tick();
        chk("eof_cnt", eof_cnt, 1);
        chk("eof_time", last_eof_cyc, cp + 3);
        chk("line_wrap", o_line_idx, 0);

        // Overrun: fifth pixel without a line advance.
        do_pixel(0, 0);
        do_pixel(1, 0);
        do_pixel(2, 0);
        do_pixel(3, 1);
        chk("pre_ovr_err", o_err, 0);
        do_pixel(0, 0);
        chk("ovr_err", o_err, 2);
        i_err_clr = 1'b1; tick(); i_err_clr = 1'b0; tick();
        chk("ovr_clr", o_err, 0);
        pulse_p(cp);
        repeat (4) tick();
        chk("line_after_ovr", o_line_idx, 1);

        // Sequence error: two reset-gate falls with no signal fall between.
        s0 = shs_cnt; r0 = shr_cnt;
        pulse_r(c1);
        repeat (12) tick();
        chk("seq_shr1", last_shr_cyc, c1 + 7);
        pulse_r(c2);
        repeat (12) tick();
        chk("seq_shr2", last_shr_cyc, c2 + 7);
        chk("seq_shr_cnt", shr_cnt - r0, 2);
        chk("seq_no_shs", shs_cnt - s0, 0);
        chk("seq_err", o_err, 1);
        i_err_clr = 1'b1; tick(); i_err_clr = 1'b0; tick();
        chk("seq_clr", o_err, 0);
        pulse_l2(cl);
        repeat (10) tick();
        chk("resync_time", last_shs_cyc, cl + 7);
        chk("resync_pix", last_pix, 0);

        // Collision: line advance on the same edge as pixel 2's strobe.
        do_pixel(1, 0);
        e0 = eof_cnt;
        pulse_r(c1);
        repeat (18) tick();
        pulse_l2(cl);
        repeat (4) tick();
        pulse_p(cp);
        repeat (6) tick();
        chk("col_shs_time", last_shs_cyc, cl + 7);
        chk("col_pix", last_pix, 2);
        chk("col_line", o_line_idx, 0);
        chk("col_eof", eof_cnt - e0, 1);
        chk("col_eof_time", last_eof_cyc, cl + 7);
        do_pixel(0, 0);

        // Enable drop during the signal delay drops the strobe and clears counters.
        pulse_p(cp);
        repeat (4) tick();
        do_pixel(0, 0);
        do_pixel(1, 0);
        chk("pre_abort_pix", o_pix_idx, 1);
        chk("pre_abort_line", o_line_idx, 1);
        s0 = shs_cnt;
        pulse_r(c1);
        repeat (18) tick();
        pulse_l2(cl);
        tick(); tick();
        i_enable = 1'b0;
        repeat (8) tick();
        chk("abort_no_shs", shs_cnt - s0, 0);
        chk("abort_pix", o_pix_idx, 0);
        chk("abort_line", o_line_idx, 0);
        chk("abort_err", o_err, 0);
        i_enable = 1'b1;
        repeat (3) tick();
        do_pixel(0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
